// File: rtl/store_channel_responder.sv
// Memory-side responder for the data-cache store channel: turns one lane-aligned store
// into a word-aligned, byte-strobed memory write and reports completion with a done pulse.
module store_channel_responder #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        store_request_i,
    input  logic [31:0] store_address_i,
    input  logic [1:0]  store_width_i,
    input  logic [31:0] store_data_i,
    output logic        store_done_o,
    output logic        error_o,
    output logic        busy_o,
    output logic        mem_wr_valid_o,
    input  logic        mem_wr_ready_i,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_strobe_o,
    input  logic        mem_ack_i,
    input  logic        mem_error_i
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        DONE
    } state_e;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    strobe_q, strobe_d;
    logic          error_q, error_d;
    logic [CW-1:0] count_q, count_d;
    logic          done_q, err_out_q;
    logic [3:0]    req_strobe;
    logic          req_misaligned;
    logic          timeout_hit;

    // Lane mask and alignment check for the incoming request; unknown widths are rejected.
    always_comb begin
        req_strobe     = 4'b0000;
        req_misaligned = 1'b0;
        case (store_width_i)
            WIDTH_BYTE: req_strobe = 4'b0001 << store_address_i[1:0];
            WIDTH_HALF: begin
                req_strobe     = store_address_i[1] ? 4'b1100 : 4'b0011;
                req_misaligned = store_address_i[0];
            end
            WIDTH_WORD: begin
                req_strobe     = 4'b1111;
                req_misaligned = |store_address_i[1:0];
            end
            default: req_misaligned = 1'b1;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count_q == LIMIT);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        strobe_d = strobe_q;
        error_d  = error_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (store_request_i) begin
                    addr_d   = {store_address_i[31:2], 2'b00};
                    data_d   = store_data_i;
                    strobe_d = req_strobe;
                    count_d  = '0;
                    error_d  = req_misaligned;
                    state_d  = req_misaligned ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                count_d = count_q + CW'(1);
                if (mem_wr_ready_i) begin
                    state_d = WAIT_ACK;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    error_d = 1'b1;
                end
            end
            // An ack arriving together with the ISSUE handshake is never seen here.
            WAIT_ACK: begin
                count_d = count_q + CW'(1);
                if (mem_ack_i) begin
                    state_d = DONE;
                    error_d = mem_error_i;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    error_d = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            strobe_q  <= '0;
            error_q   <= 1'b0;
            count_q   <= '0;
            done_q    <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
            error_q   <= error_d;
            count_q   <= count_d;
            done_q    <= (state_d == DONE);
            err_out_q <= (state_d == DONE) && error_d;
        end
    end

    assign store_done_o   = done_q;
    assign error_o        = err_out_q;
    assign busy_o         = (state_q != IDLE);
    assign mem_wr_valid_o = (state_q == ISSUE);
    assign mem_address_o  = addr_q;
    assign mem_data_o     = data_q;
    assign mem_strobe_o   = strobe_q;

endmodule

// File: tb/tb_store_channel_responder.sv
// Directed bench for store_channel_responder: a transaction-level model checked every
// cycle, plus literal expectations for latency, lane strobes and error cases.
module tb_store_channel_responder;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic [1:0]  width = '0;
    logic [31:0] data = '0;
    logic        done;
    logic        err;
    logic        busy;
    logic        valid;
    logic        ready = 1'b0;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic [3:0]  memStrobe;
    logic        ack = 1'b0;
    logic        memErr = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    bit checkEn = 1'b0;

    always #5 clk = ~clk;

    store_channel_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i          (clk),
        .rst_n_i        (rstN),
        .store_request_i(req),
        .store_address_i(addr),
        .store_width_i  (width),
        .store_data_i   (data),
        .store_done_o   (done),
        .error_o        (err),
        .busy_o         (busy),
        .mem_wr_valid_o (valid),
        .mem_wr_ready_i (ready),
        .mem_address_o  (memAddr),
        .mem_data_o     (memData),
        .mem_strobe_o   (memStrobe),
        .mem_ack_i      (ack),
        .mem_error_i    (memErr)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sizeOf(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit isLegal(input logic [1:0] w, input logic [31:0] a);
        if (w == 2'd3) return 1'b0;
        return (a % sizeOf(w)) == 0;
    endfunction

    function automatic logic [3:0] laneMask(input logic [1:0] w, input logic [31:0] a);
        logic [3:0] m = 4'b0000;
        int off = int'(a % 4);
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + sizeOf(w)) m[i] = 1'b1;
        return m;
    endfunction

    // Transaction-level model: one outstanding store, its age, and whether memory took it.
    bit          mActive = 0, mAccepted = 0, mDone = 0, mErr = 0;
    int          mAge = 0;
    logic [31:0] mAddr = '0, mData = '0;
    logic [3:0]  mStrobe = '0;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mActive = 0; mAccepted = 0; mDone = 0; mErr = 0; mAge = 0;
        end else if (mDone) begin
            mDone = 0; mErr = 0;
        end else if (!mActive) begin
            if (req) begin
                mAddr   = addr - (addr % 4);
                mData   = data;
                mStrobe = laneMask(width, addr);
                if (isLegal(width, addr)) begin
                    mActive = 1; mAccepted = 0; mAge = 0;
                end else begin
                    mDone = 1; mErr = 1;
                end
            end
        end else begin
            if (!mAccepted) begin
                if (ready) mAccepted = 1;
                else if (mAge == TO - 1) begin mActive = 0; mDone = 1; mErr = 1; end
            end else begin
                if (ack) begin mActive = 0; mDone = 1; mErr = memErr; end
                else if (mAge == TO - 1) begin mActive = 0; mDone = 1; mErr = 1; end
            end
            mAge++;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busy", busy, mActive || mDone);
            checkOutput("valid", valid, mActive && !mAccepted);
            checkOutput("done", done, mDone);
            checkOutput("error", err, mDone && mErr);
            if (mActive && !mAccepted) begin
                checkOutput("mem_address", memAddr, mAddr);
                checkOutput("mem_data", memData, mData);
                checkOutput("mem_strobe", memStrobe, mStrobe);
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; width = w; addr = a; data = d;
        stepCycle();
        req = 1'b0;
    endtask

    localparam logic [1:0]  TW [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    localparam logic [31:0] TA [4] = '{32'h1003, 32'h1001, 32'h2000, 32'h3000};
    localparam logic [31:0] TD [4] = '{32'hAB000000, 32'h0000CD00, 32'h0000BEEF, 32'hDEADBEEF};
    localparam logic [31:0] TWA[4] = '{32'h1000, 32'h1000, 32'h2000, 32'h3000};
    localparam logic [3:0]  TS [4] = '{4'b1000, 4'b0010, 4'b0011, 4'b1111};

    initial begin
        int validCycles;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset done", done, 0);
        checkOutput("reset error", err, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset valid", valid, 0);
        checkOutput("reset mem_address", memAddr, 0);
        checkOutput("reset mem_data", memData, 0);
        checkOutput("reset mem_strobe", memStrobe, 0);
        rstN = 1'b1;
        checkEn = 1'b1;
        stepCycle();

        // Aligned stores with immediate ready and ack: done three cycles after request.
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(TW[i], TA[i], TD[i]);
            checkOutput("table valid", valid, 1);
            checkOutput("table address", memAddr, TWA[i]);
            checkOutput("table strobe", memStrobe, TS[i]);
            checkOutput("table data", memData, TD[i]);
            stepCycle();
            checkOutput("table early done", done, 0);
            ack = 1'b1;
            stepCycle();
            ack = 1'b0;
            checkOutput("table done", done, 1);
            checkOutput("table error", err, 0);
            stepCycle();
            checkOutput("table done drop", done, 0);
        end

        // Half-word with memory back-pressure for five cycles.
        ready = 1'b0;
        applyStimulus(2'd1, 32'h2002, 32'hBEEF0000);
        checkOutput("half strobe", memStrobe, 4'b1100);
        checkOutput("half address", memAddr, 32'h2000);
        repeat (5) stepCycle();
        checkOutput("half valid held", valid, 1);
        checkOutput("half data held", memData, 32'hBEEF0000);
        ready = 1'b1;
        stepCycle();
        checkOutput("half not done", done, 0);
        ack = 1'b1;
        stepCycle();
        ack = 1'b0;
        checkOutput("half done", done, 1);
        stepCycle();

        // Misaligned and undefined-width stores complete with error, no memory write.
        applyStimulus(2'd2, 32'h3001, 32'h11223344);
        checkOutput("misaligned word done", done, 1);
        checkOutput("misaligned word error", err, 1);
        checkOutput("misaligned word valid", valid, 0);
        stepCycle();
        checkOutput("misaligned done drop", done, 0);
        applyStimulus(2'd1, 32'h2001, 32'h0000AA00);
        checkOutput("misaligned half error", err, 1);
        stepCycle();

        // Memory-side error on the ack.
        applyStimulus(2'd2, 32'h4000, 32'h12345678);
        stepCycle();
        ack = 1'b1; memErr = 1'b1;
        stepCycle();
        ack = 1'b0; memErr = 1'b0;
        checkOutput("mem error done", done, 1);
        checkOutput("mem error flag", err, 1);
        stepCycle();
        checkOutput("mem error idle busy", busy, 0);
        checkOutput("mem error done drop", done, 0);

        // Timeout while memory never accepts the write.
        ready = 1'b0;
        applyStimulus(2'd0, 32'h5002, 32'h00770000);
        validCycles = 0;
        for (int i = 0; i < 20 && valid; i++) begin
            validCycles++;
            stepCycle();
        end
        checkOutput("timeout valid cycles", validCycles, TO);
        checkOutput("timeout done", done, 1);
        checkOutput("timeout error", err, 1);
        stepCycle();
        ready = 1'b1;
        applyStimulus(2'd0, 32'h5000, 32'h00000055);
        stepCycle();
        ack = 1'b1;
        stepCycle();
        ack = 1'b0;
        checkOutput("after timeout done", done, 1);
        checkOutput("after timeout error", err, 0);
        stepCycle();

        // Timeout waiting for the ack, then a late ack that must be ignored.
        applyStimulus(2'd2, 32'h5800, 32'hCAFEF00D);
        repeat (TO) stepCycle();
        checkOutput("ack timeout done", done, 1);
        checkOutput("ack timeout error", err, 1);
        stepCycle();
        ack = 1'b1;
        stepCycle();
        ack = 1'b0;
        checkOutput("late ack busy", busy, 0);
        checkOutput("late ack done", done, 0);
        stepCycle();

        // Second request while busy is dropped; reset in WAIT_ACK aborts silently.
        applyStimulus(2'd2, 32'h6000, 32'h66666666);
        req = 1'b1; width = 2'd2; addr = 32'h7000; data = 32'h77777777;
        stepCycle();
        req = 1'b0;
        checkOutput("ignored request address", memAddr, 32'h6000);
        checkOutput("wait ack busy", busy, 1);
        rstN = 1'b0;
        #1;
        checkOutput("mid reset busy", busy, 0);
        checkOutput("mid reset done", done, 0);
        checkOutput("mid reset valid", valid, 0);
        checkOutput("mid reset address", memAddr, 0);
        checkOutput("mid reset data", memData, 0);
        checkOutput("mid reset strobe", memStrobe, 0);
        stepCycle();
        ack = 1'b1;
        stepCycle();
        ack = 1'b0;
        rstN = 1'b1;
        stepCycle();
        checkOutput("post reset done", done, 0);
        checkOutput("post reset busy", busy, 0);

        applyStimulus(2'd3, 32'h8000, 32'h0);
        checkOutput("bad width done", done, 1);
        checkOutput("bad width error", err, 1);
        repeat (3) stepCycle();

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
